// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART transmit scheduler
//
// Contents:
//   UART_DATA_W      width of one UART data byte
//   BIT_CNT_MAX_DEF  default clk cycles per UART bit
//   state_t          transmitter FSM state encoding (S_IDLE .. S_GAP)
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int BIT_CNT_MAX_DEF = 100000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching from a pointer
//
// Ports:
//   i_req    requester vector
//   i_ptr    index of the highest-priority requester
//   i_en     arbitration enable; with it low no grant is issued
//   o_grant  one-hot grant (combinational)
//   o_idx    encoded index of the granted requester (combinational)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx
);

    logic w_found;

    // Walk the requesters cyclically starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_en && !w_found && i_req[IW'((int'(i_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                o_grant[IW'((int'(i_ptr) + k) % NUM_REQ)] = 1'b1;
                o_idx = IW'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin shared UART transmitter (start/8 data/stop + idle gap bits)
//
// Optional feature macro: UART_TX_SCHED_PARITY_EN adds an even-parity bit between data and stop.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   req_valid  per-requester byte available
//   req_data   byte of requester i at [8*i+7:8*i]
//   req_ready  one-hot, one-cycle accept pulse (combinational, IDLE only)
//   dout       registered UART serial line, idle high
//   busy       high from the cycle after accept until return to IDLE
//   grant_id   index of the requester whose frame is in flight
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int BIT_CNT_MAX = BIT_CNT_MAX_DEF,
    parameter int GAP_BITS    = 1,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW         = $clog2(BIT_CNT_MAX)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           dout,
    output logic                           busy,
    output logic [IW-1:0]                  grant_id
);

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [3:0]             r_gap_cnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          r_grant_id;
    logic                   r_dout;
    logic                   r_busy;
`ifdef UART_TX_SCHED_PARITY_EN
    logic                   r_parity;
`endif

    logic [NUM_REQ-1:0]     w_grant;
    logic [IW-1:0]          w_idx;
    logic                   w_any;
    logic                   w_bit_end;
    logic [UART_DATA_W-1:0] w_sel_byte;
    logic [IW-1:0]          w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (r_state == S_IDLE),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_any      = |w_grant;
    assign w_bit_end  = (r_cnt == CW'(BIT_CNT_MAX - 1));
    // With NUM_REQ=1 w_idx is always 0, so the pointer stays 0.
    assign w_ptr_next = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_byte = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_gap_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_dout     <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            // Bit timer is held at 0 in IDLE so START begins a full bit period.
            r_cnt <= (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_shift    <= w_sel_byte;
                        r_grant_id <= w_idx;
                        r_ptr      <= w_ptr_next;
                        r_state    <= S_START;
                        r_dout     <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
                        r_parity   <= ^w_sel_byte;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_dout    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                            r_state <= S_PARITY;
                            r_dout  <= r_parity;
`else
                            r_state <= S_STOP;
                            r_dout  <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            // Next bit is shift[1] because the shift lands on this same edge.
                            r_dout    <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_dout  <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        if (GAP_BITS == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (w_bit_end) begin
                        if (r_gap_cnt == 4'(GAP_BITS - 1)) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dout  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_grant;
    assign dout      = r_dout;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched (NUM_REQ=2, BIT_CNT_MAX=4, GAP_BITS=1)
module tb_uart_tx_sched;

    localparam int NREQ = 2;
    localparam int BCM  = 4;
    localparam int GAP  = 1;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int FRAME_BITS = 11 + GAP;
`else
    localparam int FRAME_BITS = 10 + GAP;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              dout;
    logic              busy;
    logic [0:0]        grant_id;

    int n_cmp = 0;
    int n_err = 0;
    int ptr   = 0;   // reference round-robin pointer

    uart_tx_sched #(
        .NUM_REQ     (NREQ),
        .BIT_CNT_MAX (BCM),
        .GAP_BITS    (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dout      (dout),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit b of a frame carrying byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_SCHED_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dout", 32'(dout), 32'd1);
        @(posedge clk); #1;
    endtask

    // Expects an accept in the current cycle, then checks the whole frame cycle by cycle.
    // next_valid is applied right after the accept; pulse is OR'd in during data bit 2.
    task automatic expect_frame(input logic [1:0] next_valid, input logic [1:0] pulse, input bit refresh);
        int g;
        logic [7:0] byte_e;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        end
        chk("have_valid", 32'(g >= 0), 32'd1);
        if (g < 0) g = 0;
        byte_e = req_data[8*g +: 8];
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'(1 << g));
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_dout", 32'(dout), 32'd1);
        ptr = (g + 1) % NREQ;
        @(posedge clk); #1;
        req_valid = next_valid;
        if (refresh) req_data[8*g +: 8] = 8'($urandom);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < BCM; c++) begin
                if (b == 3 && c == 0) req_valid = next_valid | pulse;
                if (b == 4 && c == 0) req_valid = next_valid;
                @(negedge clk);
                chk($sformatf("dout_b%0d_c%0d", b, c), 32'(dout), 32'(exp_bit(byte_e, b)));
                chk("frame_busy", 32'(busy), 32'd1);
                chk("frame_ready", 32'(req_ready), 32'd0);
                chk("frame_grant_id", 32'(grant_id), 32'(g));
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [1:0] mask;
        logic [1:0] nmask;

        // Reset held, then released with no requests.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) idle_cycle();

        // Both requesters continuously valid: grants 0,1,0,1 with each next accept
        // in the first IDLE cycle after the 44-cycle frame.
        req_data = 16'h2211;
        req_valid = 2'b11;
        expect_frame(2'b11, 2'b00, 1'b0);
        expect_frame(2'b11, 2'b00, 1'b0);
        expect_frame(2'b11, 2'b00, 1'b0);
        expect_frame(2'b00, 2'b00, 1'b0);
        idle_cycle();

        // Single byte 0xA5 from requester 0.
        req_data[7:0] = 8'hA5;
        req_valid = 2'b01;
        expect_frame(2'b00, 2'b00, 1'b0);
        idle_cycle();
        idle_cycle();

        // Requester 1 pulses valid mid-frame only; the next frame still serves requester 0.
        req_data = 16'h3C5A;
        req_valid = 2'b01;
        expect_frame(2'b01, 2'b10, 1'b0);
        req_data[7:0] = 8'h96;
        expect_frame(2'b00, 2'b00, 1'b0);
        idle_cycle();

        // Reset during data bit 3 of 0xFF, then the pointer must be back at 0.
        req_data[7:0] = 8'hFF;
        req_valid = 2'b01;
        @(negedge clk);
        chk("abort_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (17) @(posedge clk);
        #1;
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_dout", 32'(dout), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ptr = 0;
        idle_cycle();
        req_data = {8'($urandom), 8'($urandom)};
        req_valid = 2'b11;
        expect_frame(2'b00, 2'b00, 1'b1);
        idle_cycle();

        // Random masks and bytes against the reference model.
        mask = 2'($urandom_range(1, 3));
        req_data = {8'($urandom), 8'($urandom)};
        req_valid = mask;
        for (int it = 0; it < 12; it++) begin
            nmask = 2'($urandom_range(0, 3));
            if (req_valid == 2'b00) begin
                idle_cycle();
                req_valid = nmask;
            end else begin
                expect_frame(nmask, 2'b00, 1'b1);
            end
        end
        req_valid = 2'b00;
        if (busy) begin
            for (int i = 0; i < FRAME_BITS * BCM + 2 && busy; i++) @(posedge clk);
            #1;
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
